// File: rtl/noc_pkg.sv
// Shared NoC definitions: byte width default, generator FSM states, packet field widths.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package noc_pkg;

   localparam int NOC_BYTE_DW = 8;    // default byte lane width
   localparam int NOC_ADDR_W  = 4;    // router address width
   localparam int NOC_CNT_W   = 16;   // packet counter / sequence / beat index width

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } ntg_state_t;

   // Counters wrap naturally at 2**NOC_CNT_W.
   function automatic logic [NOC_CNT_W-1:0] cnt_inc(input logic [NOC_CNT_W-1:0] v);
      return v + NOC_CNT_W'(1);
   endfunction

endpackage

// File: rtl/noc_traffic_generator.sv
// Purpose: AXI-Stream style NoC packet generator; emits fixed-length numbered packets to one dest.
// Latency: first beat valid one cycle after the enable-sampling edge; all outputs registered.
// Backpressure: master_* hold stable while tvalid=1 and tready=0; tvalid only drops after a handshake.
//
// Ports:
//   clk, reset (async active-low)     enable: level, run while high
//   src_address / dest_address        own / target router (dest latched at packet start)
//   master_t*                         stream output; tdata = {pkt_seq, beat_idx} halves
//   done                              run of num_pkts packets complete (held until reset)
//   pkt_count                         packets fully sent (also the packet sequence number)
module noc_traffic_generator
   import noc_pkg::*;
#(
   parameter int noc_dw     = 32,
   parameter int byte_dw    = NOC_BYTE_DW,
   parameter int pkt_len    = 4,
   parameter int num_pkts   = 16,
   parameter int gap_cycles = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [NOC_ADDR_W-1:0]     src_address,
   input  logic [NOC_ADDR_W-1:0]     dest_address,
   input  logic                      master_tready,
   output logic                      master_tvalid,
   output logic [noc_dw-1:0]         master_tdata,
   output logic [noc_dw/byte_dw-1:0] master_tstrb,
   output logic [noc_dw/byte_dw-1:0] master_tkeep,
   output logic [byte_dw-1:0]        master_tid,
   output logic [byte_dw-1:0]        master_tdest,
   output logic [byte_dw-1:0]        master_tuser,
   output logic                      master_tlast,
   output logic                      done,
   output logic [NOC_CNT_W-1:0]      pkt_count
);

   localparam int STRB_W = noc_dw / byte_dw;
   localparam int HALF_W = noc_dw / 2;

   localparam logic [NOC_CNT_W-1:0] LAST_BEAT = NOC_CNT_W'(pkt_len - 1);
   localparam logic [NOC_CNT_W-1:0] PKT_LIMIT = NOC_CNT_W'(num_pkts);
   localparam logic [NOC_CNT_W-1:0] GAP_LAST  = NOC_CNT_W'((gap_cycles > 0) ? gap_cycles - 1 : 0);
   localparam bit                   UNLIMITED = (num_pkts == 0);
   localparam bit                   HAS_GAP   = (gap_cycles > 0);

   // State and counters. pkt_count doubles as the packet sequence number:
   // both start at zero and advance on the same edge, so one register serves both.
   ntg_state_t             r_state;
   logic [NOC_CNT_W-1:0]   r_beat_idx;
   logic [NOC_CNT_W-1:0]   r_pkt_count;
   logic [NOC_CNT_W-1:0]   r_gap_cnt;
   logic [NOC_ADDR_W-1:0]  r_dest;

   // Registered outputs
   logic                   r_tvalid;
   logic [noc_dw-1:0]      r_tdata;
   logic [STRB_W-1:0]      r_tstrb;
   logic [STRB_W-1:0]      r_tkeep;
   logic [byte_dw-1:0]     r_tid;
   logic [byte_dw-1:0]     r_tdest;
   logic [byte_dw-1:0]     r_tuser;
   logic                   r_tlast;
   logic                   r_done;

   // Next-state values
   ntg_state_t             w_state_nxt;
   logic [NOC_CNT_W-1:0]   w_beat_nxt;
   logic [NOC_CNT_W-1:0]   w_count_nxt;
   logic [NOC_CNT_W-1:0]   w_gap_nxt;
   logic [NOC_ADDR_W-1:0]  w_dest_nxt;
   logic                   w_vld_nxt;
   logic                   w_done_nxt;
   logic                   w_load;        // present a new beat on the bus this edge

   logic [NOC_CNT_W-1:0]   w_count_inc;
   logic                   w_quota_met;
   logic                   w_last_pkt;
   logic [noc_dw-1:0]      w_tdata_nxt;

   assign w_count_inc = cnt_inc(r_pkt_count);
   assign w_quota_met = !UNLIMITED && (r_pkt_count >= PKT_LIMIT);
   assign w_last_pkt  = !UNLIMITED && (w_count_inc == PKT_LIMIT);
   assign w_tdata_nxt = {HALF_W'(w_count_nxt), HALF_W'(w_beat_nxt)};

   always_comb begin
      w_state_nxt = r_state;
      w_beat_nxt  = r_beat_idx;
      w_count_nxt = r_pkt_count;
      w_gap_nxt   = r_gap_cnt;
      w_dest_nxt  = r_dest;
      w_vld_nxt   = r_tvalid;
      w_done_nxt  = r_done;
      w_load      = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            if (w_quota_met) begin
               w_state_nxt = ST_DONE;
               w_vld_nxt   = 1'b0;
               w_done_nxt  = 1'b1;
            end else if (enable) begin
               w_state_nxt = ST_SEND;
               w_dest_nxt  = dest_address;
               w_beat_nxt  = '0;
               w_vld_nxt   = 1'b1;
               w_load      = 1'b1;
            end
         end

         ST_SEND: begin
            // Nothing moves until the current beat is taken, which keeps
            // every master_* output frozen during a stall.
            if (r_tvalid && master_tready) begin
               if (r_beat_idx != LAST_BEAT) begin
                  w_beat_nxt = cnt_inc(r_beat_idx);
                  w_load     = 1'b1;
               end else begin
                  w_count_nxt = w_count_inc;
                  w_beat_nxt  = '0;
                  if (w_last_pkt) begin
                     w_state_nxt = ST_DONE;
                     w_vld_nxt   = 1'b0;
                     w_done_nxt  = 1'b1;
                  end else if (HAS_GAP) begin
                     w_state_nxt = ST_GAP;
                     w_gap_nxt   = '0;
                     w_vld_nxt   = 1'b0;
                  end else if (enable) begin
                     // back-to-back: next packet's first beat replaces the last one
                     w_dest_nxt = dest_address;
                     w_load     = 1'b1;
                  end else begin
                     w_state_nxt = ST_IDLE;
                     w_vld_nxt   = 1'b0;
                  end
               end
            end
         end

         ST_GAP: begin
            // The edge ending the gap is also the start-of-packet edge, so the
            // bus sees exactly gap_cycles idle cycles.
            if (r_gap_cnt == GAP_LAST) begin
               w_gap_nxt = '0;
               if (enable) begin
                  w_state_nxt = ST_SEND;
                  w_dest_nxt  = dest_address;
                  w_vld_nxt   = 1'b1;
                  w_load      = 1'b1;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end else begin
               w_gap_nxt = cnt_inc(r_gap_cnt);
            end
         end

         ST_DONE: begin
            w_vld_nxt  = 1'b0;
            w_done_nxt = 1'b1;
         end

         default: begin
            w_state_nxt = ST_IDLE;
            w_vld_nxt   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_beat_idx  <= '0;
         r_pkt_count <= '0;
         r_gap_cnt   <= '0;
         r_dest      <= '0;
         r_tvalid    <= 1'b0;
         r_tdata     <= '0;
         r_tstrb     <= '0;
         r_tkeep     <= '0;
         r_tid       <= '0;
         r_tdest     <= '0;
         r_tuser     <= '0;
         r_tlast     <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_beat_idx  <= w_beat_nxt;
         r_pkt_count <= w_count_nxt;
         r_gap_cnt   <= w_gap_nxt;
         r_dest      <= w_dest_nxt;
         r_tvalid    <= w_vld_nxt;
         r_done      <= w_done_nxt;
         if (w_load) begin
            r_tdata <= w_tdata_nxt;
            r_tstrb <= '1;
            r_tkeep <= '1;
            r_tid   <= byte_dw'(src_address);
            r_tdest <= byte_dw'(w_dest_nxt);
            r_tuser <= byte_dw'(w_count_nxt);
            r_tlast <= (w_beat_nxt == LAST_BEAT);
         end else if (!w_vld_nxt) begin
            r_tlast <= 1'b0;
         end
      end
   end

   assign master_tvalid = r_tvalid;
   assign master_tdata  = r_tdata;
   assign master_tstrb  = r_tstrb;
   assign master_tkeep  = r_tkeep;
   assign master_tid    = r_tid;
   assign master_tdest  = r_tdest;
   assign master_tuser  = r_tuser;
   assign master_tlast  = r_tlast;
   assign done          = r_done;
   assign pkt_count     = r_pkt_count;

endmodule

// File: tb/tb_noc_traffic_generator.sv
// Self-checking bench for noc_traffic_generator.
// Two instances: A (pkt_len=4, num_pkts=2, gap=2) and B (pkt_len=1, num_pkts=3, gap=0).
// Negedge monitors score accepted beats against queues filled by the test tasks.
`timescale 1ns/1ps
module tb_noc_traffic_generator;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  strb;
      logic [3:0]  keep;
      logic [7:0]  tid;
      logic [7:0]  dest;
      logic [7:0]  user;
      logic        last;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n;
   logic [3:0] src_addr;
   logic [3:0] dest_addr;

   logic        a_enable, a_tready, a_tvalid, a_tlast, a_done;
   logic [31:0] a_tdata;
   logic [3:0]  a_tstrb, a_tkeep;
   logic [7:0]  a_tid, a_tdest, a_tuser;
   logic [15:0] a_pkt_count;

   logic        b_enable, b_tready, b_tvalid, b_tlast, b_done;
   logic [31:0] b_tdata;
   logic [3:0]  b_tstrb, b_tkeep;
   logic [7:0]  b_tid, b_tdest, b_tuser;
   logic [15:0] b_pkt_count;

   noc_traffic_generator #(
      .noc_dw(32), .byte_dw(8), .pkt_len(4), .num_pkts(2), .gap_cycles(2)
   ) u_dut_a (
      .clk(clk), .reset(reset_n), .enable(a_enable),
      .src_address(src_addr), .dest_address(dest_addr),
      .master_tready(a_tready), .master_tvalid(a_tvalid), .master_tdata(a_tdata),
      .master_tstrb(a_tstrb), .master_tkeep(a_tkeep), .master_tid(a_tid),
      .master_tdest(a_tdest), .master_tuser(a_tuser), .master_tlast(a_tlast),
      .done(a_done), .pkt_count(a_pkt_count)
   );

   noc_traffic_generator #(
      .noc_dw(32), .byte_dw(8), .pkt_len(1), .num_pkts(3), .gap_cycles(0)
   ) u_dut_b (
      .clk(clk), .reset(reset_n), .enable(b_enable),
      .src_address(src_addr), .dest_address(dest_addr),
      .master_tready(b_tready), .master_tvalid(b_tvalid), .master_tdata(b_tdata),
      .master_tstrb(b_tstrb), .master_tkeep(b_tkeep), .master_tid(b_tid),
      .master_tdest(b_tdest), .master_tuser(b_tuser), .master_tlast(b_tlast),
      .done(b_done), .pkt_count(b_pkt_count)
   );

   beat_t a_exp_q[$];
   beat_t b_exp_q[$];
   int    a_acc_q[$];
   int    b_acc_q[$];
   int    total = 0;
   int    bad   = 0;
   int    cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   logic [65:0] a_snap, a_prev_snap, b_snap, b_prev_snap;
   logic        a_prev_stall = 1'b0;
   logic        b_prev_stall = 1'b0;
   beat_t       a_obs, a_exp, b_obs, b_exp;

   assign a_snap = {a_tvalid, a_tdata, a_tstrb, a_tkeep, a_tid, a_tdest, a_tuser, a_tlast};
   assign b_snap = {b_tvalid, b_tdata, b_tstrb, b_tkeep, b_tid, b_tdest, b_tuser, b_tlast};

   // Monitor A: stall stability, tvalid persistence, beat scoreboard.
   always @(negedge clk) begin
      if (!reset_n) begin
         a_prev_stall = 1'b0;
      end else begin
         if (a_prev_stall) begin
            total++;
            if (a_snap !== a_prev_snap) begin
               bad++;
               $display("FAIL a_stall_hold: got %h need %h", a_snap, a_prev_snap);
            end
         end
         if (a_tvalid && a_tready) begin
            a_acc_q.push_back(cyc + 1);
            a_obs = {a_tdata, a_tstrb, a_tkeep, a_tid, a_tdest, a_tuser, a_tlast};
            total++;
            if (a_exp_q.size() == 0) begin
               bad++;
               $display("FAIL a_unexpected_beat: got %h need no beat", a_obs);
            end else begin
               a_exp = a_exp_q.pop_front();
               if (a_obs !== a_exp) begin
                  bad++;
                  $display("FAIL a_beat: got %h need %h", a_obs, a_exp);
               end
            end
         end
         a_prev_stall = a_tvalid && !a_tready;
         a_prev_snap  = a_snap;
      end
   end

   // Monitor B: same checks for the single-beat back-to-back instance.
   always @(negedge clk) begin
      if (!reset_n) begin
         b_prev_stall = 1'b0;
      end else begin
         if (b_prev_stall) begin
            total++;
            if (b_snap !== b_prev_snap) begin
               bad++;
               $display("FAIL b_stall_hold: got %h need %h", b_snap, b_prev_snap);
            end
         end
         if (b_tvalid && b_tready) begin
            b_acc_q.push_back(cyc + 1);
            b_obs = {b_tdata, b_tstrb, b_tkeep, b_tid, b_tdest, b_tuser, b_tlast};
            total++;
            if (b_exp_q.size() == 0) begin
               bad++;
               $display("FAIL b_unexpected_beat: got %h need no beat", b_obs);
            end else begin
               b_exp = b_exp_q.pop_front();
               if (b_obs !== b_exp) begin
                  bad++;
                  $display("FAIL b_beat: got %h need %h", b_obs, b_exp);
               end
            end
         end
         b_prev_stall = b_tvalid && !b_tready;
         b_prev_snap  = b_snap;
      end
   end

   // Queue the first nbeats beats of packet seq (packet length len) for instance A or B.
   task automatic push_pkt(input bit to_b, input int seq, input int nbeats, input int len,
                           input logic [3:0] dest);
      beat_t e;
      for (int i = 0; i < nbeats; i++) begin
         e.data = {seq[15:0], i[15:0]};
         e.strb = 4'hF;
         e.keep = 4'hF;
         e.tid  = {4'h0, src_addr};
         e.dest = {4'h0, dest};
         e.user = seq[7:0];
         e.last = (i == len - 1);
         if (to_b) b_exp_q.push_back(e);
         else      a_exp_q.push_back(e);
      end
   endtask

   task automatic do_reset();
      reset_n  = 1'b0;
      a_enable = 1'b0;
      b_enable = 1'b0;
      a_tready = 1'b0;
      b_tready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      a_exp_q.delete();
      b_exp_q.delete();
      a_acc_q.delete();
      b_acc_q.delete();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n  = 1'b0;
      a_enable = 1'b1;
      b_enable = 1'b0;
      a_tready = 1'b0;
      b_tready = 1'b0;
      @(posedge clk);
      #3;
      total++;
      if ({a_snap, a_done, a_pkt_count} !== '0) begin
         bad++;
         $display("FAIL reset_a_outputs: got %h need 0", {a_snap, a_done, a_pkt_count});
      end
      total++;
      if ({b_snap, b_done, b_pkt_count} !== '0) begin
         bad++;
         $display("FAIL reset_b_outputs: got %h need 0", {b_snap, b_done, b_pkt_count});
      end
      @(posedge clk);
      #1 reset_n = 1'b1;
      #1;
      total++;
      if (a_tvalid !== 1'b0) begin
         bad++;
         $display("FAIL reset_release_no_edge: got tvalid=%b need 0", a_tvalid);
      end
      @(posedge clk);
      #1;
      total++;
      if ({a_tvalid, a_tdata, a_tdest} !== {1'b1, 32'h0, 4'h0, dest_addr}) begin
         bad++;
         $display("FAIL reset_first_edge_start: got %h need %h",
                  {a_tvalid, a_tdata, a_tdest}, {1'b1, 32'h0, 4'h0, dest_addr});
      end
   endtask

   // Basic run with tready=1, plus dest_address change mid-packet.
   task automatic test_basic();
      int t0;
      do_reset();
      dest_addr = 4'd3;
      a_tready  = 1'b1;
      push_pkt(1'b0, 0, 4, 4, 4'd3);
      push_pkt(1'b0, 1, 4, 4, 4'd5);
      @(posedge clk);
      #1;
      t0       = cyc;
      a_enable = 1'b1;
      for (int i = 0; i < 20 && a_acc_q.size() == 0; i++) @(posedge clk);
      #1 dest_addr = 4'd5;
      for (int i = 0; i < 60 && a_done !== 1'b1; i++) @(posedge clk);
      #1;
      total++;
      if ({a_done, a_pkt_count, a_tvalid} !== {1'b1, 16'd2, 1'b0}) begin
         bad++;
         $display("FAIL basic_done: got done=%b count=%0d tvalid=%b need 1 2 0",
                  a_done, a_pkt_count, a_tvalid);
      end
      total++;
      if (a_exp_q.size() != 0) begin
         bad++;
         $display("FAIL basic_all_beats: got %0d beats missing need 0", a_exp_q.size());
      end
      total++;
      if (a_acc_q.size() != 8) begin
         bad++;
         $display("FAIL basic_beat_count: got %0d need 8", a_acc_q.size());
      end else begin
         total++;
         if (a_acc_q[0] != t0 + 2) begin
            bad++;
            $display("FAIL basic_first_latency: got edge %0d need %0d", a_acc_q[0], t0 + 2);
         end
         total++;
         if (a_acc_q[3] - a_acc_q[0] != 3) begin
            bad++;
            $display("FAIL basic_pkt0_contiguous: got %0d need 3", a_acc_q[3] - a_acc_q[0]);
         end
         total++;
         if (a_acc_q[4] - a_acc_q[3] != 3) begin
            bad++;
            $display("FAIL basic_gap: got spacing %0d need 3", a_acc_q[4] - a_acc_q[3]);
         end
      end
      repeat (5) @(posedge clk);
      #1;
      total++;
      if ({a_done, a_tvalid} !== 2'b10) begin
         bad++;
         $display("FAIL basic_done_hold: got done=%b tvalid=%b need 1 0", a_done, a_tvalid);
      end
   endtask

   // Random tready; monitors check stability during every stall.
   task automatic test_stall();
      do_reset();
      dest_addr = 4'd5;
      push_pkt(1'b0, 0, 4, 4, 4'd5);
      push_pkt(1'b0, 1, 4, 4, 4'd5);
      a_enable = 1'b1;
      for (int i = 0; i < 400 && a_done !== 1'b1; i++) begin
         @(posedge clk);
         #1 a_tready = 1'($urandom_range(0, 1));
      end
      #1;
      total++;
      if ({a_done, a_pkt_count} !== {1'b1, 16'd2}) begin
         bad++;
         $display("FAIL stall_done: got done=%b count=%0d need 1 2", a_done, a_pkt_count);
      end
      total++;
      if (a_exp_q.size() != 0) begin
         bad++;
         $display("FAIL stall_all_beats: got %0d missing need 0", a_exp_q.size());
      end
   endtask

   // Instance B: single-beat packets, no gap.
   task automatic test_back_to_back();
      do_reset();
      dest_addr = 4'd7;
      b_tready  = 1'b1;
      for (int k = 0; k < 3; k++) push_pkt(1'b1, k, 1, 1, 4'd7);
      @(posedge clk);
      #1 b_enable = 1'b1;
      for (int i = 0; i < 20 && b_done !== 1'b1; i++) @(posedge clk);
      #1;
      total++;
      if ({b_done, b_pkt_count, b_tvalid} !== {1'b1, 16'd3, 1'b0}) begin
         bad++;
         $display("FAIL b2b_done: got done=%b count=%0d tvalid=%b need 1 3 0",
                  b_done, b_pkt_count, b_tvalid);
      end
      total++;
      if (b_exp_q.size() != 0) begin
         bad++;
         $display("FAIL b2b_all_beats: got %0d missing need 0", b_exp_q.size());
      end
      total++;
      if (b_acc_q.size() != 3) begin
         bad++;
         $display("FAIL b2b_beat_count: got %0d need 3", b_acc_q.size());
      end else begin
         total++;
         if (b_acc_q[1] - b_acc_q[0] != 1 || b_acc_q[2] - b_acc_q[1] != 1) begin
            bad++;
            $display("FAIL b2b_continuous: got edges %0d %0d %0d need consecutive",
                     b_acc_q[0], b_acc_q[1], b_acc_q[2]);
         end
      end
   endtask

   // enable dropped after beat 1: packet finishes, idle, then resumes with seq 1.
   task automatic test_enable_drop();
      do_reset();
      dest_addr = 4'd3;
      a_tready  = 1'b1;
      push_pkt(1'b0, 0, 4, 4, 4'd3);
      a_enable = 1'b1;
      for (int i = 0; i < 20 && a_acc_q.size() < 2; i++) @(posedge clk);
      #1 a_enable = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      total++;
      if ({a_tvalid, a_pkt_count, a_done} !== {1'b0, 16'd1, 1'b0}) begin
         bad++;
         $display("FAIL endrop_idle: got tvalid=%b count=%0d done=%b need 0 1 0",
                  a_tvalid, a_pkt_count, a_done);
      end
      total++;
      if (a_exp_q.size() != 0 || a_acc_q.size() != 4) begin
         bad++;
         $display("FAIL endrop_finish_pkt: got missing=%0d accepted=%0d need 0 4",
                  a_exp_q.size(), a_acc_q.size());
      end
      push_pkt(1'b0, 1, 4, 4, 4'd3);
      a_enable = 1'b1;
      for (int i = 0; i < 30 && a_done !== 1'b1; i++) @(posedge clk);
      #1;
      total++;
      if ({a_done, a_pkt_count} !== {1'b1, 16'd2} || a_exp_q.size() != 0) begin
         bad++;
         $display("FAIL endrop_resume: got done=%b count=%0d missing=%0d need 1 2 0",
                  a_done, a_pkt_count, a_exp_q.size());
      end
   endtask

   // Reset during a stalled beat 2: outputs clear without a clock, restart from scratch.
   task automatic test_reset_mid();
      do_reset();
      dest_addr = 4'd3;
      a_tready  = 1'b1;
      push_pkt(1'b0, 0, 2, 4, 4'd3);
      a_enable = 1'b1;
      for (int i = 0; i < 20 && a_acc_q.size() < 2; i++) @(posedge clk);
      #1 a_tready = 1'b0;
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      total++;
      if ({a_snap, a_done, a_pkt_count} !== '0) begin
         bad++;
         $display("FAIL rstmid_async_clear: got %h need 0", {a_snap, a_done, a_pkt_count});
      end
      @(posedge clk);
      #1;
      a_exp_q.delete();
      a_acc_q.delete();
      push_pkt(1'b0, 0, 4, 4, 4'd3);
      push_pkt(1'b0, 1, 4, 4, 4'd3);
      a_tready = 1'b1;
      reset_n  = 1'b1;
      for (int i = 0; i < 60 && a_done !== 1'b1; i++) @(posedge clk);
      #1;
      total++;
      if ({a_done, a_pkt_count} !== {1'b1, 16'd2} || a_exp_q.size() != 0 || a_acc_q.size() != 8) begin
         bad++;
         $display("FAIL rstmid_restart: got done=%b count=%0d missing=%0d accepted=%0d need 1 2 0 8",
                  a_done, a_pkt_count, a_exp_q.size(), a_acc_q.size());
      end
   endtask

   initial begin
      src_addr  = 4'hA;
      dest_addr = 4'd3;
      test_reset();
      test_basic();
      test_stall();
      test_back_to_back();
      test_enable_drop();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish by 1ms need finish");
      $fatal(1, "watchdog");
   end

endmodule
